// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, addresses instruction memory and
// hands {pc, instruction} pairs to decode through a 2-entry valid/ready buffer.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic        halted_q, halted_d;

    logic        push_s;
    logic        pop_s;
    logic        flush_s;
    logic [31:0] redirect_aligned_s;

    assign redirect_aligned_s = {redirect_pc[31:2], 2'b00};
    assign pop_s              = (count_q != 2'd0) && out_ready;

    // Next-state, PC sequencing and buffer bookkeeping
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        push_s       = 1'b0;
        flush_s      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_aligned_s;
                end else begin
                    pc_d = pc_q;
                end
                if (start) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Full 30-bit compare so a wrapped PC still lands in HALT
                if (redirect_valid) begin
                    pc_d    = redirect_aligned_s;
                    flush_s = 1'b1;
                end else if (pc_q[31:2] >= MEM_WORDS_W) begin
                    state_d = S_HALT;
                end else if ((count_q != 2'd2) || pop_s) begin
                    push_s = 1'b1;
                    pc_d   = pc_q + 32'd4;
                end else begin
                    pc_d = pc_q;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_aligned_s;
                    flush_s = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush discards everything, including a same-cycle pop
        if (flush_s) begin
            count_d = 2'd0;
        end else begin
            if (pop_s && (count_q == 2'd2)) begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
            end else begin
                head_instr_d = head_instr_d;
            end
            if (push_s) begin
                if ((count_q == 2'd0) || ((count_q == 2'd1) && pop_s)) begin
                    head_instr_d = imem_instruction;
                    head_pc_d    = pc_q;
                end else begin
                    tail_instr_d = imem_instruction;
                    tail_pc_d    = pc_q;
                end
            end else begin
                tail_instr_d = tail_instr_d;
            end
            count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
        end

        halted_d = (state_d == S_HALT);
    end

    // State, PC and buffer registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            count_q      <= 2'd0;
            head_instr_q <= 32'd0;
            head_pc_q    <= 32'd0;
            tail_instr_q <= 32'd0;
            tail_pc_q    <= 32'd0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_addr       = {2'b00, pc_q[31:2]};
    assign out_valid       = (count_q != 2'd0);
    assign out_instruction = head_instr_q;
    assign out_pc          = head_pc_q;
    assign halted          = halted_q;

endmodule
